// File: rtl/axi4lite_req_master_if.sv
// Bundle of local request/response and AXI4-Lite master channels.
// The master modport is the request master's view; slave is the far side.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 64
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

interface axi4lite_req_master_if #(
  parameter int ADDR_W = `AXI4_ADDR_BITS,
  parameter int DATA_W = `AXI4_DATA_BITS,
  parameter int STRB_W = DATA_W/8
);
  // local request / response
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_we;
  logic [ADDR_W-1:0]          req_addr;
  logic [DATA_W-1:0]          req_wdata;
  logic [STRB_W-1:0]          req_wstrb;
  logic [`AXI4_PROT_BITS-1:0] req_prot;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_we;
  logic [DATA_W-1:0]          rsp_rdata;
  logic [`AXI4_RESP_BITS-1:0] rsp_resp;
  // write address
  logic                       m_axi4lite_aw_valid;
  logic                       m_axi4lite_aw_ready;
  logic [ADDR_W-1:0]          m_axi4lite_aw_addr;
  logic [`AXI4_PROT_BITS-1:0] m_axi4lite_aw_prot;
  // write data
  logic                       m_axi4lite_w_valid;
  logic                       m_axi4lite_w_ready;
  logic [DATA_W-1:0]          m_axi4lite_w_data;
  logic [STRB_W-1:0]          m_axi4lite_w_strb;
  // write response
  logic                       m_axi4lite_b_valid;
  logic                       m_axi4lite_b_ready;
  logic [`AXI4_RESP_BITS-1:0] m_axi4lite_b_resp;
  // read address
  logic                       m_axi4lite_ar_valid;
  logic                       m_axi4lite_ar_ready;
  logic [ADDR_W-1:0]          m_axi4lite_ar_addr;
  logic [`AXI4_PROT_BITS-1:0] m_axi4lite_ar_prot;
  // read data
  logic                       m_axi4lite_r_valid;
  logic                       m_axi4lite_r_ready;
  logic [DATA_W-1:0]          m_axi4lite_r_data;
  logic [`AXI4_RESP_BITS-1:0] m_axi4lite_r_resp;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    output m_axi4lite_aw_valid, m_axi4lite_aw_addr, m_axi4lite_aw_prot,
    input  m_axi4lite_aw_ready,
    output m_axi4lite_w_valid, m_axi4lite_w_data, m_axi4lite_w_strb,
    input  m_axi4lite_w_ready,
    input  m_axi4lite_b_valid, m_axi4lite_b_resp,
    output m_axi4lite_b_ready,
    output m_axi4lite_ar_valid, m_axi4lite_ar_addr, m_axi4lite_ar_prot,
    input  m_axi4lite_ar_ready,
    input  m_axi4lite_r_valid, m_axi4lite_r_data, m_axi4lite_r_resp,
    output m_axi4lite_r_ready
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb, req_prot, rsp_ready,
    input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    input  m_axi4lite_aw_valid, m_axi4lite_aw_addr, m_axi4lite_aw_prot,
    output m_axi4lite_aw_ready,
    input  m_axi4lite_w_valid, m_axi4lite_w_data, m_axi4lite_w_strb,
    output m_axi4lite_w_ready,
    output m_axi4lite_b_valid, m_axi4lite_b_resp,
    input  m_axi4lite_b_ready,
    input  m_axi4lite_ar_valid, m_axi4lite_ar_addr, m_axi4lite_ar_prot,
    output m_axi4lite_ar_ready,
    output m_axi4lite_r_valid, m_axi4lite_r_data, m_axi4lite_r_resp,
    input  m_axi4lite_r_ready
  );
endinterface

// File: rtl/axi4lite_req_master.sv
// Single-outstanding AXI4-Lite master: turns one local request into one
// AXI4-Lite read or write and returns the captured response.
`ifndef AXI4_ADDR_BITS
`define AXI4_ADDR_BITS 32
`endif
`ifndef AXI4_DATA_BITS
`define AXI4_DATA_BITS 64
`endif
`ifndef AXI4_PROT_BITS
`define AXI4_PROT_BITS 3
`endif
`ifndef AXI4_RESP_BITS
`define AXI4_RESP_BITS 2
`endif

module axi4lite_req_master #(
  parameter int ADDR_W = `AXI4_ADDR_BITS,
  parameter int DATA_W = `AXI4_DATA_BITS,
  parameter int STRB_W = DATA_W/8
) (
  input  logic                  clk,
  input  logic                  rstn,
  axi4lite_req_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                     r_state;
  logic                       r_aw_valid, r_w_valid, r_ar_valid;
  logic                       r_aw_done, r_w_done;
  logic                       r_we;
  logic [ADDR_W-1:0]          r_addr;
  logic [DATA_W-1:0]          r_wdata;
  logic [STRB_W-1:0]          r_wstrb;
  logic [`AXI4_PROT_BITS-1:0] r_prot;
  logic [DATA_W-1:0]          r_rsp_rdata;
  logic [`AXI4_RESP_BITS-1:0] r_rsp_resp;

  state_t w_state_nxt;
  logic   w_aw_valid_nxt, w_w_valid_nxt, w_ar_valid_nxt;
  logic   w_aw_done_nxt, w_w_done_nxt;
  logic   w_cap_req, w_cap_b, w_cap_r;
  logic   w_aw_hs, w_w_hs, w_ar_hs;

  // handshakes only count while our registered valid is up
  assign w_aw_hs = r_aw_valid & bus.m_axi4lite_aw_ready;
  assign w_w_hs  = r_w_valid  & bus.m_axi4lite_w_ready;
  assign w_ar_hs = r_ar_valid & bus.m_axi4lite_ar_ready;

  // next-state and next-valid decode; valids are registered from these
  always_comb begin
    w_state_nxt    = r_state;
    w_aw_valid_nxt = r_aw_valid;
    w_w_valid_nxt  = r_w_valid;
    w_ar_valid_nxt = r_ar_valid;
    w_aw_done_nxt  = r_aw_done;
    w_w_done_nxt   = r_w_done;
    w_cap_req      = 1'b0;
    w_cap_b        = 1'b0;
    w_cap_r        = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          w_cap_req     = 1'b1;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
          if (bus.req_we) begin
            w_state_nxt    = WR_AW_W;
            w_aw_valid_nxt = 1'b1;
            w_w_valid_nxt  = 1'b1;
          end else begin
            w_state_nxt    = RD_AR;
            w_ar_valid_nxt = 1'b1;
          end
        end
      end
      WR_AW_W: begin
        // AW and W complete independently, in any order
        if (w_aw_hs) begin
          w_aw_valid_nxt = 1'b0;
          w_aw_done_nxt  = 1'b1;
        end
        if (w_w_hs) begin
          w_w_valid_nxt = 1'b0;
          w_w_done_nxt  = 1'b1;
        end
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_state_nxt   = WR_B;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      WR_B: begin
        if (bus.m_axi4lite_b_valid) begin
          w_cap_b     = 1'b1;
          w_state_nxt = RSP;
        end
      end
      RD_AR: begin
        if (w_ar_hs) begin
          w_ar_valid_nxt = 1'b0;
          w_state_nxt    = RD_R;
        end
      end
      RD_R: begin
        if (bus.m_axi4lite_r_valid) begin
          w_cap_r     = 1'b1;
          w_state_nxt = RSP;
        end
      end
      RSP: begin
        // no request acceptance here; IDLE is re-entered first
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: begin
        // illegal encoding: recover to a clean idle
        w_state_nxt    = IDLE;
        w_aw_valid_nxt = 1'b0;
        w_w_valid_nxt  = 1'b0;
        w_ar_valid_nxt = 1'b0;
        w_aw_done_nxt  = 1'b0;
        w_w_done_nxt   = 1'b0;
      end
    endcase
  end

  // state, valid and done-flag registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_aw_valid <= 1'b0;
      r_w_valid  <= 1'b0;
      r_ar_valid <= 1'b0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_aw_valid <= w_aw_valid_nxt;
      r_w_valid  <= w_w_valid_nxt;
      r_ar_valid <= w_ar_valid_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_w_done   <= w_w_done_nxt;
    end
  end

  // request payload capture; held stable for the whole transaction
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_prot  <= '0;
    end else if (w_cap_req) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_wstrb <= bus.req_wstrb;
      r_prot  <= bus.req_prot;
    end
  end

  // response capture from B or R; error codes pass through untouched
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= '0;
    end else if (w_cap_b) begin
      r_rsp_rdata <= '0;
      r_rsp_resp  <= bus.m_axi4lite_b_resp;
    end else if (w_cap_r) begin
      r_rsp_rdata <= bus.m_axi4lite_r_data;
      r_rsp_resp  <= bus.m_axi4lite_r_resp;
    end
  end

  assign bus.req_ready          = (r_state == IDLE);
  assign bus.rsp_valid          = (r_state == RSP);
  assign bus.rsp_we             = r_we;
  assign bus.rsp_rdata          = r_rsp_rdata;
  assign bus.rsp_resp           = r_rsp_resp;

  assign bus.m_axi4lite_aw_valid = r_aw_valid;
  assign bus.m_axi4lite_aw_addr  = r_addr;
  assign bus.m_axi4lite_aw_prot  = r_prot;
  assign bus.m_axi4lite_w_valid  = r_w_valid;
  assign bus.m_axi4lite_w_data   = r_wdata;
  assign bus.m_axi4lite_w_strb   = r_wstrb;
  assign bus.m_axi4lite_b_ready  = (r_state == WR_B);
  assign bus.m_axi4lite_ar_valid = r_ar_valid;
  assign bus.m_axi4lite_ar_addr  = r_addr;
  assign bus.m_axi4lite_ar_prot  = r_prot;
  assign bus.m_axi4lite_r_ready  = (r_state == RD_R);

endmodule

// File: doc/axi4lite_req_master.md
AXI4LITE_REQ_MASTER -- requirements
Module: axi4lite_req_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W   `AXI4_ADDR_BITS   AXI address width
  DATA_W   `AXI4_DATA_BITS   AXI data width
  STRB_W   DATA_W/8          write strobe width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk  in  1  sole clock; all logic on rising edge
  rstn  in  1  reset, synchronous, active-low
  req_valid  in  1  local request valid
  req_ready  out  1  local request accepted when valid&ready
  req_we  in  1  1=write, 0=read
  req_addr  in  ADDR_W  byte address
  req_wdata  in  DATA_W  write data (ignored for reads)
  req_wstrb  in  STRB_W  byte enables (ignored for reads)
  req_prot  in  `AXI4_PROT_BITS  protection, driven on AW or AR prot
  rsp_valid  out  1  response valid
  rsp_ready  in  1  response consumed when valid&ready
  rsp_we  out  1  echo of req_we for this response
  rsp_rdata  out  DATA_W  read data; 0 for writes
  rsp_resp  out  `AXI4_RESP_BITS  captured BRESP/RRESP
  m_axi4lite_aw_{valid,addr,prot} out, aw_ready in  AXI4-Lite write address channel
  m_axi4lite_w_{valid,data,strb} out, w_ready in  AXI4-Lite write data channel
  m_axi4lite_b_{valid,resp} in, b_ready out  AXI4-Lite write response channel
  m_axi4lite_ar_{valid,addr,prot} out, ar_ready in  AXI4-Lite read address channel
  m_axi4lite_r_{valid,data,resp} in, r_ready out  AXI4-Lite read data channel

Function
REQ-003 Block SHALL have exactly one transaction outstanding at a time.
REQ-004 FSM states SHALL be IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RSP.
REQ-005 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-006 On req handshake, addr/wdata/wstrb/prot/we SHALL be captured into registers; next state WR_AW_W if we=1, else RD_AR.
REQ-007 All m_axi4lite_*_valid outputs SHALL be registered; valid SHALL be asserted in the cycle after request acceptance (1-cycle latency) and SHALL NOT depend combinationally on any ready input.
REQ-008 Once asserted, a valid SHALL stay 1 with stable payload until its handshake cycle, then drop on the next edge.
REQ-009 In WR_AW_W, aw_valid and w_valid SHALL assert together; aw_done/w_done flags SHALL track each handshake independently, in either order or the same cycle.
REQ-010 WR_AW_W SHALL exit to WR_B at the edge where both handshakes are complete (flag set or handshake this cycle).
REQ-011 b_ready SHALL be 1 only in WR_B; on b handshake, b_resp SHALL be captured into rsp_resp, rsp_rdata set to 0, next state RSP.
REQ-012 In RD_AR, ar_valid SHALL be 1; on ar handshake, next state RD_R.
REQ-013 r_ready SHALL be 1 only in RD_R; on r handshake, r_data/r_resp SHALL be captured, next state RSP.
REQ-014 In RSP, rsp_valid SHALL be 1 with stable rsp_* until rsp_ready=1; then next state IDLE.
REQ-015 No new request SHALL be accepted in RSP, even when rsp_ready=1.
REQ-016 b_valid outside WR_B and r_valid outside RD_R SHALL be ignored, with no state change.
REQ-017 Non-OKAY responses (SLVERR/DECERR) SHALL be passed through unchanged in rsp_resp, with no retry.
REQ-018 Unused encodings of the state register SHALL return to IDLE with all valids 0.

Reset
REQ-019 While rstn=0 at a rising edge, the state SHALL go to IDLE, aw_done and w_done to 0, and all AXI valids, rsp_valid, b_ready and r_ready to 0.
REQ-020 After reset, rsp_rdata and rsp_resp SHALL be 0, and m_axi4lite addr/data/strb/prot outputs SHALL be 0.
REQ-021 Reset asserted mid-transaction SHALL abandon that transaction silently; no rsp_valid SHALL follow.

Verification
REQ-022 Write: req addr=0x40, data=0x1122334455667788, strb=0xFF, slave readies always 1, B OKAY two cycles after AW/W -> aw_valid and w_valid high exactly 1 cycle, then rsp_valid with rsp_we=1, resp=00, rdata=0.
REQ-023 Split write: aw_ready held 0 for 3 cycles, w accepted at once -> w_valid drops after 1 cycle, aw_valid stays high with addr stable until ready, b_ready rises only after AW handshake.
REQ-024 Read: req addr=0x80, slave returns r_data=0xDEADBEEFCAFEF00D with RESP=10 -> rsp_rdata=0xDEADBEEFCAFEF00D, rsp_resp=10, rsp_we=0.
REQ-025 Backpressure: rsp_ready held 0 for 5 cycles -> rsp_valid and payload stable; req_ready=0 throughout; req_ready=1 the cycle after the rsp handshake.
REQ-026 Reset during WR_B (b_valid not yet given) -> next cycle all valids and ready outputs are 0, state is IDLE, no rsp_valid; a following read completes normally.
REQ-027 Stray b_valid=1 injected while IDLE -> no b_ready, no rsp_valid, req_ready stays 1.
